spi_target_arbiter: RTL and testbench

- Shares the slave MCU's parallel SPI byte port between NUM_TARGETS HLE peripherals (servo HLE on index 0, other HLE targets above it).
- Routes each byte to one owning target, returns that target's MISO with zero latency, and ends transactions on chip-select release or idle timeout.
- Merges the targets' mode-fault quirk requests into the single quirk_force_mode_fault line towards the MCU model.

---
 rtl/spi_target_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spi_target_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_target_arbiter.sv
// Shares one parallel SPI byte port among NUM_TARGETS HLE targets and merges their mode-fault requests.
// Optional per-target byte counters are enabled by defining SPI_ARB_STATS_EN.
module spi_target_arbiter #(
  parameter int NUM_TARGETS  = 2,
  parameter int IDLE_TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_write,
  input  logic [7:0]               m_mosi,
  output logic [7:0]               m_miso,
  input  logic [NUM_TARGETS-1:0]   m_sel,
  output logic [NUM_TARGETS-1:0]   t_write,
  output logic [7:0]               t_mosi,
  input  logic [8*NUM_TARGETS-1:0] t_miso,
  input  logic [NUM_TARGETS-1:0]   t_mode_fault,
  output logic                     quirk_force_mode_fault,
  output logic                     busy,
  output logic [1:0]               owner,
  output logic                     err_collision,
  output logic                     err_nosel,
  output logic [15:0]              stat_count,
  input  logic [1:0]               stat_idx
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             owner_nxt, route;
  logic                   route_vld, owner_selected, owner_hit, issue;
  logic [11:0]            timeout, timeout_nxt;
  logic [NUM_TARGETS-1:0] owner_oh, src_oh, pending, pending_nxt, pending_low;
  logic                   quirk_nxt, coll_nxt, nosel_nxt;

  function automatic logic [1:0] lowest_set(input logic [NUM_TARGETS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
      if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  // Routing: owner keeps the port while its select is held, otherwise lowest requester wins
  always_comb begin
    owner_oh = '0;
    for (int k = 0; k < NUM_TARGETS; k++)
      owner_oh[k] = (owner == 2'(k));
    owner_selected = (state == OWNED) && |(m_sel & owner_oh);
    if (owner_selected) begin
      route     = owner;
      route_vld = 1'b1;
    end else begin
      route     = lowest_set(m_sel);
      route_vld = |m_sel;
    end
    t_mosi  = m_mosi;
    t_write = '0;
    m_miso  = 8'hFF;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (route_vld && route == 2'(k)) begin
        m_miso     = t_miso[8*k +: 8];
        t_write[k] = m_write & ~reset;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    timeout_nxt = timeout;
    coll_nxt    = 1'b0;
    nosel_nxt   = 1'b0;
    if (m_write) begin
      if (owner_selected) begin
        timeout_nxt = 12'(IDLE_TIMEOUT);
      end else if (|m_sel) begin
        state_nxt   = OWNED;
        owner_nxt   = route;
        timeout_nxt = 12'(IDLE_TIMEOUT);
        coll_nxt    = ($countones(m_sel) > 1);
      end else begin
        state_nxt = IDLE;
        nosel_nxt = 1'b1;
      end
    end else if (state == OWNED) begin
      if (!owner_selected || timeout == 12'd1) state_nxt = IDLE;
      else                                     timeout_nxt = timeout - 12'd1;
    end
  end

  // Fault source is the target that owns (or is just acquiring) the port this cycle
  always_comb begin
    src_oh = '0;
    if (m_write && !owner_selected && |m_sel) begin
      for (int k = 0; k < NUM_TARGETS; k++)
        src_oh[k] = (route == 2'(k));
    end else if (state == OWNED) begin
      src_oh = owner_oh;
    end
    pending_low = '0;
    for (int k = NUM_TARGETS - 1; k >= 0; k--)
      if (pending[k]) begin
        pending_low    = '0;
        pending_low[k] = 1'b1;
      end
    owner_hit   = |(t_mode_fault & src_oh);
    issue       = !owner_hit && (state == IDLE) && !quirk_force_mode_fault && |pending;
    pending_nxt = pending | (t_mode_fault & ~src_oh);
    if (issue) pending_nxt = pending_nxt & ~pending_low;
    quirk_nxt = owner_hit | issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      owner                  <= '0;
      timeout                <= '0;
      pending                <= '0;
      quirk_force_mode_fault <= 1'b0;
      err_collision          <= 1'b0;
      err_nosel              <= 1'b0;
    end else begin
      state                  <= state_nxt;
      owner                  <= owner_nxt;
      timeout                <= timeout_nxt;
      pending                <= pending_nxt;
      quirk_force_mode_fault <= quirk_nxt;
      err_collision          <= coll_nxt;
      err_nosel              <= nosel_nxt;
    end
  end

  assign busy = (state == OWNED);

`ifdef SPI_ARB_STATS_EN
  logic [15:0] cnt [NUM_TARGETS];
  logic [15:0] stat_sel;

  always_comb begin
    stat_sel = '0;
    for (int k = 0; k < NUM_TARGETS; k++)
      if (stat_idx == 2'(k)) stat_sel = cnt[k];
  end

  // Counters saturate rather than wrap so a long session never reads as a short one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_TARGETS; k++) cnt[k] <= '0;
      stat_count <= '0;
    end else begin
      for (int k = 0; k < NUM_TARGETS; k++)
        if (t_write[k] && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
      stat_count <= stat_sel;
    end
  end
`else
  logic unused_stat_idx;
  assign unused_stat_idx = ^stat_idx;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_spi_target_arbiter.sv
// Directed-vector bench for spi_target_arbiter (2 targets, 4095-cycle idle timeout).
module tb_spi_target_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m_write;
  logic [7:0]  m_mosi;
  logic [7:0]  m_miso;
  logic [1:0]  m_sel;
  logic [1:0]  t_write;
  logic [7:0]  t_mosi;
  logic [15:0] t_miso;
  logic [1:0]  t_mode_fault;
  logic        quirk_force_mode_fault;
  logic        busy;
  logic [1:0]  owner;
  logic        err_collision;
  logic        err_nosel;
  logic [15:0] stat_count;
  logic [1:0]  stat_idx;

  int checks = 0;
  int failures = 0;

  spi_target_arbiter #(.NUM_TARGETS(2), .IDLE_TIMEOUT(4095)) dut (
    .clk(clk), .reset(reset), .m_write(m_write), .m_mosi(m_mosi), .m_miso(m_miso),
    .m_sel(m_sel), .t_write(t_write), .t_mosi(t_mosi), .t_miso(t_miso),
    .t_mode_fault(t_mode_fault), .quirk_force_mode_fault(quirk_force_mode_fault),
    .busy(busy), .owner(owner), .err_collision(err_collision), .err_nosel(err_nosel),
    .stat_count(stat_count), .stat_idx(stat_idx)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; m_write = 1'b1; m_mosi = 8'h3C; m_sel = 2'b01;
    t_miso = 16'h0000; t_mode_fault = 2'b00; stat_idx = 2'd0;
    @(posedge clk); #1;
    checks++; if (t_write !== 2'b00) begin failures++; $display("FAIL rst_t_write got=%b exp=00", t_write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner); end
    checks++; if ({quirk_force_mode_fault, err_collision, err_nosel} !== 3'b000) begin
      failures++; $display("FAIL rst_pulses got=%b exp=000", {quirk_force_mode_fault, err_collision, err_nosel}); end
    checks++; if (stat_count !== 16'h0000) begin failures++; $display("FAIL rst_stat got=%h exp=0000", stat_count); end
    @(negedge clk); m_write = 1'b0; reset = 1'b0; m_sel = 2'b00;
  endtask

  task automatic test_basic();
    logic [7:0] mosi_v [4] = '{8'hB0, 8'h00, 8'h00, 8'h00};
    logic [7:0] miso_v [4] = '{8'h55, 8'h61, 8'h01, 8'h01};
    m_sel = 2'b01;
    for (int i = 0; i < 4; i++) begin
      m_write = 1'b1; m_mosi = mosi_v[i]; t_miso = {8'hAA, miso_v[i]};
      #1;
      checks++; if (m_miso !== miso_v[i]) begin failures++; $display("FAIL basic_miso%0d got=%h exp=%h", i, m_miso, miso_v[i]); end
      checks++; if (t_write !== 2'b01 || t_mosi !== mosi_v[i]) begin
        failures++; $display("FAIL basic_fwd%0d t_write=%b t_mosi=%h exp=01/%h", i, t_write, t_mosi, mosi_v[i]); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy%0d got=%b exp=1", i, busy); end
      @(negedge clk);
    end
    m_write = 1'b0; m_sel = 2'b00;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_release got=%b exp=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_collision();
    m_sel = 2'b11; m_write = 1'b1; m_mosi = 8'hDD; t_miso = 16'h77EE;
    #1;
    checks++; if (m_miso !== 8'hEE) begin failures++; $display("FAIL coll_miso got=%h exp=EE", m_miso); end
    checks++; if (t_write !== 2'b01) begin failures++; $display("FAIL coll_t_write got=%b exp=01", t_write); end
    @(posedge clk); #1;
    checks++; if (err_collision !== 1'b1) begin failures++; $display("FAIL coll_pulse got=%b exp=1", err_collision); end
    checks++; if (owner !== 2'd0 || busy !== 1'b1) begin failures++; $display("FAIL coll_owner got=%0d/%b exp=0/1", owner, busy); end
    @(negedge clk); m_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (err_collision !== 1'b0) begin failures++; $display("FAIL coll_one_cycle got=%b exp=0", err_collision); end
    @(negedge clk);
  endtask

  task automatic test_switch();
    m_sel = 2'b10; m_write = 1'b1; m_mosi = 8'hA6; t_miso = 16'hCCEE;
    #1;
    checks++; if (t_write !== 2'b10 || m_miso !== 8'hCC) begin
      failures++; $display("FAIL switch_route t_write=%b miso=%h exp=10/CC", t_write, m_miso); end
    @(posedge clk); #1;
    checks++; if (owner !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL switch_owner got=%0d/%b exp=1/1", owner, busy); end
    checks++; if (err_collision !== 1'b0) begin failures++; $display("FAIL switch_coll got=%b exp=0", err_collision); end
    @(negedge clk); m_write = 1'b0; m_sel = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int fall;
    fall = -1;
    m_sel = 2'b01; m_write = 1'b1; m_mosi = 8'h11; t_miso = 16'h0042;
    @(negedge clk); m_write = 1'b0;
    for (int i = 1; i <= 4200; i++) begin
      @(posedge clk); #1;
      if (!busy) begin fall = i; break; end
    end
    checks++; if (fall != 4095) begin failures++; $display("FAIL timeout_len got=%0d exp=4095", fall); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL timeout_owner_hold got=%0d exp=0", owner); end
    @(negedge clk); m_sel = 2'b00; m_write = 1'b1; m_mosi = 8'h5A;
    #1;
    checks++; if (m_miso !== 8'hFF || t_write !== 2'b00) begin
      failures++; $display("FAIL nosel_drop miso=%h t_write=%b exp=FF/00", m_miso, t_write); end
    @(posedge clk); #1;
    checks++; if (err_nosel !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL nosel_pulse err=%b busy=%b exp=1/0", err_nosel, busy); end
    @(negedge clk); m_write = 1'b0;
    @(posedge clk); #1;
    checks++; if (err_nosel !== 1'b0) begin failures++; $display("FAIL nosel_one_cycle got=%b exp=0", err_nosel); end
    @(negedge clk);
  endtask

  task automatic test_mode_fault();
    int pulses, first;
    pulses = 0; first = -1;
    m_sel = 2'b01; m_write = 1'b1; m_mosi = 8'h01;
    @(negedge clk); m_write = 1'b0; t_mode_fault = 2'b10;
    @(posedge clk); #1;
    checks++; if (quirk_force_mode_fault !== 1'b0) begin failures++; $display("FAIL mf_nonowner_immediate got=1 exp=0"); end
    @(negedge clk); t_mode_fault = 2'b01;
    @(posedge clk); #1;
    checks++; if (quirk_force_mode_fault !== 1'b1) begin failures++; $display("FAIL mf_owner_pulse got=0 exp=1"); end
    @(negedge clk); t_mode_fault = 2'b00;
    @(posedge clk); #1;
    checks++; if (quirk_force_mode_fault !== 1'b0) begin failures++; $display("FAIL mf_owner_width got=1 exp=0"); end
    @(negedge clk); m_sel = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (quirk_force_mode_fault) begin pulses++; if (first < 0) first = i; end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL mf_pending_count got=%0d exp=1", pulses); end
    checks++; if (first != 2) begin failures++; $display("FAIL mf_pending_cycle got=%0d exp=2", first); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m_sel = 2'b01; m_write = 1'b1; m_mosi = 8'h77;
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || t_write !== 2'b00) begin
      failures++; $display("FAIL rst_mid busy=%b t_write=%b exp=0/00", busy, t_write); end
    @(negedge clk); reset = 1'b0; m_write = 1'b0; m_sel = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_stats();
`ifdef SPI_ARB_STATS_EN
    m_sel = 2'b01; m_write = 1'b1; stat_idx = 2'd0;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    m_write = 1'b0; m_sel = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (stat_count !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h exp=FFFF", stat_count); end
`else
    m_sel = 2'b01; m_write = 1'b1; stat_idx = 2'd0;
    repeat (3) @(negedge clk);
    m_write = 1'b0; m_sel = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (stat_count !== 16'h0000) begin failures++; $display("FAIL stats_absent got=%h exp=0000", stat_count); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_switch();
    test_timeout();
    test_mode_fault();
    test_reset_mid();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
